// File: rtl/axis_pkt_capture_pkg.sv
// Shared types and helpers for the packet capture block.
// Holds the FSM state encoding and the tkeep byte counter.
// No logic of its own; imported by axis_pkt_capture.
package axis_pkt_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2,
    DRAIN   = 2'd3
  } cap_state_t;

  // Widest tkeep the popcount helper accepts; narrower keeps are zero-extended.
  localparam int KEEP_MAX = 64;

  // Number of set bits in a tkeep vector (valid bytes in a low-aligned beat).
  function automatic logic [31:0] keep_popcount(input logic [KEEP_MAX-1:0] keep);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      cnt = cnt + 32'(keep[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/AXIS_int.sv
// AXI4-Stream bundle: data, byte keep, user, last, valid/ready.
// Pure wiring, no latency.
// Backpressure is the usual tvalid/tready handshake.
interface AXIS_int #(
  parameter int DATA_BYTES = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport Master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport Slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_pkt_capture.sv
// Captures one AXIS packet into a flat MTU-sized buffer and holds it until acked.
// Latency: packet presented on pkt_* the cycle after its last beat is accepted.
// Backpressure: tready is low only while a packet is held; oversize packets are drained and counted.
module axis_pkt_capture
  import axis_pkt_capture_pkg::*;
#(
  parameter int MTU_BYTES  = 1500,
  parameter int DATA_BYTES = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     aresetn,
  AXIS_int.Slave                   axis_in,
  output logic                     pkt_valid,
  input  logic                     pkt_ack,
  output logic [31:0]              pkt_byte_length,
  output logic [USER_WIDTH-1:0]    pkt_user,
  output logic [MTU_BYTES*8-1:0]   pkt_data,
  output logic [31:0]              pkt_count,
  output logic [31:0]              drop_count,
  output logic                     keep_error
);

  localparam logic [DATA_BYTES-1:0] KEEP_ALL = '1;

  cap_state_t state;
  logic       tready_q;
  logic [31:0] offset;      // bytes already stored for the packet in progress

  logic [DATA_BYTES*8-1:0] in_data;
  logic [DATA_BYTES-1:0]   in_keep;
  logic [USER_WIDTH-1:0]   in_user;
  logic                    in_last;
  logic                    in_valid;

  logic        hs;
  logic [31:0] base;
  logic [31:0] beat_bytes;
  logic [31:0] len_after;
  logic        ovf;
  logic        wr_en;

  assign in_data        = axis_in.tdata;
  assign in_keep        = axis_in.tkeep;
  assign in_user        = axis_in.tuser;
  assign in_last        = axis_in.tlast;
  assign in_valid       = axis_in.tvalid;
  assign axis_in.tready = tready_q;

  assign hs = in_valid & tready_q;

  // Length bookkeeping for the beat on the bus: where it lands and whether it fits.
  // Non-last beats always count as full; only the last beat is trimmed by tkeep.
  always_comb begin
    base       = (state == IDLE) ? 32'd0 : offset;
    beat_bytes = in_last ? keep_popcount(KEEP_MAX'(in_keep)) : 32'(DATA_BYTES);
    len_after  = base + beat_bytes;
    ovf        = (len_after > 32'(MTU_BYTES));
    wr_en      = hs && !ovf && ((state == IDLE) || (state == CAPTURE));
  end

  // Payload store: first beat of a packet wipes the buffer, kept bytes land at their offset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_data <= '0;
    end else if (wr_en) begin
      if (state == IDLE) begin
        pkt_data <= '0;
      end
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (in_keep[b]) begin
          pkt_data[(int'(base) + b)*8 +: 8] <= in_data[b*8 +: 8];
        end
      end
    end
  end

  // Capture FSM with registered tready, packet metadata and counters.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      tready_q        <= 1'b0;
      offset          <= '0;
      pkt_valid       <= 1'b0;
      pkt_byte_length <= '0;
      pkt_user        <= '0;
      pkt_count       <= '0;
      drop_count      <= '0;
      keep_error      <= 1'b0;
    end else begin
      if (hs && !in_last && (in_keep != KEEP_ALL)) begin
        keep_error <= 1'b1;
      end

      case (state)
        IDLE, CAPTURE: begin
          tready_q <= 1'b1;
          if (hs) begin
            if (state == IDLE) begin
              pkt_user <= in_user;
            end
            if (ovf) begin
              offset <= '0;
              if (in_last) begin
                drop_count <= drop_count + 32'd1;
                state      <= IDLE;
              end else begin
                state <= DRAIN;
              end
            end else if (in_last) begin
              pkt_byte_length <= len_after;
              pkt_valid       <= 1'b1;
              tready_q        <= 1'b0;
              offset          <= '0;
              state           <= HOLD;
            end else begin
              offset <= len_after;
              state  <= CAPTURE;
            end
          end
        end

        HOLD: begin
          if (pkt_ack) begin
            pkt_valid <= 1'b0;
            pkt_count <= pkt_count + 32'd1;
            tready_q  <= 1'b1;
            state     <= IDLE;
          end
        end

        DRAIN: begin
          tready_q <= 1'b1;
          if (hs && in_last) begin
            drop_count <= drop_count + 32'd1;
            state      <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          tready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/axis_pkt_capture.md
AXIS_PKT_CAPTURE -- requirements
Module: axis_pkt_capture

Interface
REQ-001 SHALL have parameter MTU_BYTES, default 1500: maximum captured packet size in bytes.
REQ-002 SHALL have parameter DATA_BYTES, default 8: AXIS beat width in bytes; must equal axis_in data width.
REQ-003 SHALL have parameter USER_WIDTH, default 1: width of captured tuser.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic is rising-edge.
REQ-005 SHALL have port aresetn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port axis_in, AXIS_int.Slave, DATA_BYTES: packet stream input.
REQ-007 SHALL have port pkt_valid, output, 1: a captured packet is held on the pkt_* outputs.
REQ-008 SHALL have port pkt_ack, input, 1: consumer releases the held packet.
REQ-009 SHALL have port pkt_byte_length, output, 32: captured length in bytes.
REQ-010 SHALL have port pkt_user, output, USER_WIDTH: tuser of the first beat.
REQ-011 SHALL have port pkt_data, output, MTU_BYTES*8: flattened payload, packet byte 0 at [7:0].
REQ-012 SHALL have port pkt_count, output, 32: packets delivered.
REQ-013 SHALL have port drop_count, output, 32: packets discarded.
REQ-014 SHALL have port keep_error, output, 1: sticky flag for a non-last beat without all-ones tkeep.

Function
REQ-015 SHALL implement states IDLE, CAPTURE, HOLD, DRAIN.
REQ-016 SHALL drive tready=1 in IDLE, CAPTURE and DRAIN, and tready=0 in HOLD.
REQ-017 SHALL, on an IDLE handshake, clear pkt_data to zero, latch tuser into pkt_user, and write the beat at byte offset 0.
REQ-018 SHALL write beat w, byte b, to pkt_data byte w*DATA_BYTES+b, only where tkeep[b]=1.
REQ-019 SHALL, on the last beat, set length = bytes before the beat + popcount(tkeep) (tkeep is low-aligned contiguous); for non-last beats, add DATA_BYTES.
REQ-020 SHALL, on a handshake with tlast=1 and no overflow, enter HOLD with pkt_valid=1 and the outputs stable on the next cycle; single-beat packets go IDLE->HOLD.
REQ-021 SHALL, in HOLD with pkt_ack=1, drop pkt_valid, increment pkt_count and return to IDLE on the next cycle; the first beat of the next packet is accepted no earlier than that cycle.
REQ-022 SHALL ignore pkt_ack while pkt_valid=0.
REQ-023 SHALL, on any beat that would place a byte beyond MTU_BYTES-1, write no further bytes and go to DRAIN (or to IDLE if that beat has tlast).
REQ-024 SHALL, in DRAIN, accept and discard beats until tlast, then increment drop_count and return to IDLE; pkt_valid stays 0.
REQ-025 SHALL set keep_error on a non-last beat with tkeep != all-ones, keep it until reset, and continue capturing that beat as if full.
REQ-026 SHALL let counters wrap modulo 2^32.
REQ-027 SHALL treat a packet of exactly MTU_BYTES bytes as valid, not overflowed.

Reset
REQ-028 SHALL, on aresetn low, asynchronously enter IDLE with tready=0, pkt_valid=0, pkt_byte_length=0, pkt_user=0, pkt_data=0, pkt_count=0, drop_count=0 and keep_error=0.
REQ-029 SHALL assert tready no earlier than the first clk edge after aresetn deasserts.
REQ-030 SHALL abandon a packet in progress at reset without counting it; after reset, any remaining beats are captured as a new packet.

Structure
REQ-031 SHALL place the state enum typedef and the keep-popcount function in package axis_pkt_capture_pkg.
REQ-032 SHALL use no sub-module; a single module with one FSM plus a byte-offset register.

Verification
REQ-033 SHALL cover: a 20-byte packet, DATA_BYTES=8, last tkeep=0x0F, user=1 -> pkt_valid with length 20, bytes 0..19 matching, bytes 20+ zero, user 1.
REQ-034 SHALL cover: a 1500-byte packet, then a 1501-byte packet -> first delivered with length 1500; second dropped with drop_count=1 and pkt_valid never asserted.
REQ-035 SHALL cover: two back-to-back packets with pkt_ack held 10 cycles late -> tready=0 for those cycles, the second packet intact, pkt_count=2.
REQ-036 SHALL cover: a 1-byte packet with tkeep=0x01 -> length 1, IDLE->HOLD directly.
REQ-037 SHALL cover: aresetn pulsed mid-packet after 3 of 6 beats -> all outputs zero, no count change, the remaining 3 beats captured as a 24-byte packet.
REQ-038 SHALL cover: a non-last beat with tkeep=0x7F -> keep_error=1 and sticky, the packet still delivered.
